// File: rtl/regfile_port_ctrl_pkg.sv
// Shared types and constants for the register-file port sequencer:
// FSM state encoding, latched transaction record and access latencies.
package regfile_port_ctrl_pkg;

   localparam int TXN_DATA_W = 16;
   localparam int TXN_ADDR_W = 5;

   // Edges from request sample to visible done/rdata.
   localparam int RD_LAT = 2;
   localparam int WR_LAT = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WS,
      ST_WP,
      ST_WH
   } state_e;

   typedef struct packed {
      logic                  we;
      logic [TXN_ADDR_W-1:0] addr_a;
      logic [TXN_ADDR_W-1:0] addr_b;
      logic [TXN_ADDR_W-1:0] addr_d;
      logic [TXN_DATA_W-1:0] wdata;
      logic                  id;
   } txn_t;

endpackage

// File: rtl/regfile_port_arb.sv
// Two-input request arbiter. Round-robin with a last-grant pointer when
// REGFILE_PORT_CTRL_RR_EN is defined, otherwise fixed priority to requester 0.
module regfile_port_arb (
`ifdef REGFILE_PORT_CTRL_RR_EN
   input  logic clk,
   input  logic rst_n,
`endif
   input  logic en,
   input  logic req0,
   input  logic req1,
   output logic pick0,
   output logic pick1
);

`ifdef REGFILE_PORT_CTRL_RR_EN
   logic last_q, last_d;

   // last_q holds the id of the previous winner; the other side wins a tie.
   always_comb begin
      pick0  = en & req0 & (~req1 | last_q);
      pick1  = en & req1 & (~req0 | ~last_q);
      last_d = last_q;
      if (pick0) begin
         last_d = 1'b0;
      end else if (pick1) begin
         last_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   always_comb begin
      pick0 = en & req0;
      pick1 = en & req1 & ~req0;
   end
`endif

endmodule

// File: rtl/regfile_port_ctrl.sv
// Arbitrates two requesters onto the register file's read ports and
// edge-triggered write port. Tie policy selected by REGFILE_PORT_CTRL_RR_EN.
module regfile_port_ctrl
   import regfile_port_ctrl_pkg::*;
#(
   // Must match the package transaction widths.
   parameter int DATA_W = TXN_DATA_W,
   parameter int ADDR_W = TXN_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr_a,
   input  logic [ADDR_W-1:0] req0_addr_b,
   input  logic [ADDR_W-1:0] req0_addr_d,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_gnt,
   output logic              req0_done,
   input  logic              req1_valid,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr_a,
   input  logic [ADDR_W-1:0] req1_addr_b,
   input  logic [ADDR_W-1:0] req1_addr_d,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_gnt,
   output logic              req1_done,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   output logic [ADDR_W-1:0] regAddrA,
   output logic [ADDR_W-1:0] regAddrB,
   output logic [ADDR_W-1:0] regAddrD,
   output logic              regReA,
   output logic              regReB,
   output logic              regWeD,
   output logic [DATA_W-1:0] busD,
   input  logic [DATA_W-1:0] busA,
   input  logic [DATA_W-1:0] busB
);

   state_e            state_q, state_d;
   txn_t              txn_q, txn_d;
   logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic              done0_q, done0_d, done1_q, done1_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
   logic              pick0, pick1;

   regfile_port_arb u_arb (
`ifdef REGFILE_PORT_CTRL_RR_EN
      .clk   (clk),
      .rst_n (rst_n),
`endif
      .en    (state_q == ST_IDLE),
      .req0  (req0_valid),
      .req1  (req1_valid),
      .pick0 (pick0),
      .pick1 (pick1)
   );

   always_comb begin
      state_d   = state_q;
      txn_d     = txn_q;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      done0_d   = 1'b0;
      done1_d   = 1'b0;
      we_d      = 1'b0;
      rdata_a_d = rdata_a_q;
      rdata_b_d = rdata_b_q;
      case (state_q)
         ST_IDLE: begin
            if (pick0 | pick1) begin
               txn_d.we     = pick1 ? req1_we     : req0_we;
               txn_d.addr_a = pick1 ? req1_addr_a : req0_addr_a;
               txn_d.addr_b = pick1 ? req1_addr_b : req0_addr_b;
               txn_d.addr_d = pick1 ? req1_addr_d : req0_addr_d;
               txn_d.wdata  = pick1 ? req1_wdata  : req0_wdata;
               txn_d.id     = pick1;
               gnt0_d       = pick0;
               gnt1_d       = pick1;
               state_d      = txn_d.we ? ST_WS : ST_RD;
            end
         end
         ST_RD: begin
            rdata_a_d = busA;
            rdata_b_d = busB;
            done0_d   = ~txn_q.id;
            done1_d   = txn_q.id;
            state_d   = ST_IDLE;
         end
         // The strobe is registered from the WS->WP transition so it is
         // a clean flop output for exactly the WP cycle.
         ST_WS: begin
            we_d    = 1'b1;
            state_d = ST_WP;
         end
         ST_WP: state_d = ST_WH;
         ST_WH: begin
            done0_d = ~txn_q.id;
            done1_d = txn_q.id;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         txn_q     <= '0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         done0_q   <= 1'b0;
         done1_q   <= 1'b0;
         we_q      <= 1'b0;
         rdata_a_q <= '0;
         rdata_b_q <= '0;
      end else begin
         state_q   <= state_d;
         txn_q     <= txn_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         done0_q   <= done0_d;
         done1_q   <= done1_d;
         we_q      <= we_d;
         rdata_a_q <= rdata_a_d;
         rdata_b_q <= rdata_b_d;
      end
   end

   // Address and write data come straight from the latched transaction,
   // so they stay stable from WS through WH.
   assign regAddrA  = txn_q.addr_a;
   assign regAddrB  = txn_q.addr_b;
   assign regAddrD  = txn_q.addr_d;
   assign busD      = txn_q.wdata;
   assign regReA    = (state_q == ST_RD);
   assign regReB    = (state_q == ST_RD);
   assign regWeD    = we_q;
   assign req0_gnt  = gnt0_q;
   assign req1_gnt  = gnt1_q;
   assign req0_done = done0_q;
   assign req1_done = done1_q;
   assign rdata_a   = rdata_a_q;
   assign rdata_b   = rdata_b_q;

endmodule

// File: doc/regfile_port_ctrl.md
# regfile_port_ctrl

Sequencer and arbiter in front of the 16-bit register file. Two requesters (decode/execute and the debug/load unit) share the register file's two tri-state read ports and its single edge-triggered write port. The block grants one transaction at a time. It drives the file's enables and addresses, and generates a clean setup/pulse/hold `regWeD` strobe. It returns captured read data with a one-cycle `done` pulse.

## Interface
Parameters:
- `DATA_W`, default 16: register data width.
- `ADDR_W`, default 5: register address width.

Ports (N = 0, 1; each `reqN_*` exists per requester):
- `clk`  in  1  single clock, all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `reqN_valid`  in  1  transaction request; hold until `reqN_gnt`.
- `reqN_we`  in  1  1 = write `reqN_wdata` to `reqN_addr_d`; 0 = read `reqN_addr_a` and `reqN_addr_b`.
- `reqN_addr_a`, `reqN_addr_b`, `reqN_addr_d`  in  ADDR_W  register addresses.
- `reqN_wdata`  in  DATA_W  write data.
- `reqN_gnt`  out  1  one-cycle pulse: request accepted, inputs latched.
- `reqN_done`  out  1  one-cycle pulse: transaction complete.
- `rdata_a`, `rdata_b`  out  DATA_W  captured read data; valid from `done` until the next read completes.
- `regAddrA`, `regAddrB`, `regAddrD`  out  ADDR_W  to register file.
- `regReA`, `regReB`, `regWeD`  out  1  to register file.
- `busD`  out  DATA_W  write data to register file.
- `busA`, `busB`  in  DATA_W  read buses from register file (tri-state; sampled only while enabled).

## Operation
- The FSM has five states: IDLE, RD, WS (write setup), WP (write pulse) and WH (write hold).
- In IDLE, arbitration happens on each rising edge over the valid requests.
  - The winner's fields are latched into an internal transaction register.
  - `reqN_gnt` pulses for the winner.
  - The FSM moves to RD (`we`=0) or WS (`we`=1).
- In RD:
  - `regReA` = `regReB` = 1.
  - `regAddrA`/`regAddrB` are driven from the latched fields.
  - At the end of the cycle, `busA`/`busB` are captured into `rdata_a`/`rdata_b`, `reqN_done` is pulsed, and the FSM returns to IDLE.
- Write path:
  - WS drives `regAddrD`/`busD` with `regWeD`=0.
  - WP drives `regWeD`=1.
  - WH drives `regWeD`=0 with address and data still held.
  - At the end of WH, `done` is pulsed and the FSM returns to IDLE.
- `regAddrD`/`busD` are held stable for the whole of WS through WH.
- `regWeD` is a registered output; it is never combinational and never glitches.
- Addresses pass through unmodified. A write to r0 completes normally, including `done`; the file discards it.
- All FSM and output registers are reset to 0. On reset:
  - The state is IDLE.
  - `rdata_a` = `rdata_b` = 0.
  - The round-robin pointer is reset to "last grant = 1", so requester 0 wins the first tie.
- Reset in WS aborts with no write. Reset in WP or WH means the write has already landed (the rising edge has occurred). No `done` is issued in either case.

## Timing
- Request sampled at edge E0, then `gnt` is high for the cycle after E0.
- Read: RD runs in the cycle after E0. `done` and `rdata` are visible after E1, so read latency is 2 edges.
- Write: WS after E0, WP after E1, WH after E2, `done` after E3, so write latency is 4 edges. `regWeD` is high for exactly one cycle.
- The `done` cycle is IDLE, so a new grant can be issued at the edge ending the `done` cycle. Maximum throughput is one read every 2 cycles.
- If a request is dropped before `gnt`, it is not serviced. Requests are not sampled while busy.

## Configuration
- Macro `REGFILE_PORT_CTRL_RR_EN`:
  - Defined: round-robin. On a tie, the requester not granted last time wins; the pointer updates on every grant.
  - Undefined: fixed priority, with requester 0 always winning ties and the pointer logic absent.

## Structure
- `regfile_port_ctrl_pkg` holds:
  - the FSM state enum;
  - the transaction struct (`we`, `addr_a`, `addr_b`, `addr_d`, `wdata`, `id`);
  - the latency constants RD_LAT=2 and WR_LAT=4.
- Sub-module `regfile_port_arb`: two-input arbiter containing the grant logic and the round-robin pointer, compiled per the macro.

## Test plan
- Read after reset:
  - Stimulus: req0 read, a=3, b=5, with the file model holding r3=0x1234 and r5=0xBEEF.
  - Required: `gnt0` after 1 edge; `done0` after 2 edges; `rdata_a`=0x1234, `rdata_b`=0xBEEF; `regReA`/`regReB` high for exactly one cycle.
- Write strobe:
  - Stimulus: req1 write, d=7, wdata=0xA5A5.
  - Required: `regAddrD`=7 and `busD`=0xA5A5 stable for 3 cycles; `regWeD` high only in the middle cycle; `done1` at edge 4; a later read of r7 returns 0xA5A5.
- Tie with `RR_EN` defined:
  - Stimulus: both requesters hold valid for 4 transactions.
  - Required: grant order 0, 1, 0, 1. Without the macro: 0, 0, 0, 0 until req0 drops.
- Write to r0:
  - Stimulus: write d=0, wdata=0xFFFF.
  - Required: `done` issued; a subsequent read of r0 returns 0.
- Reset mid-write:
  - Stimulus: assert `rst_n`=0 in WS.
  - Required: `regWeD` never rises; target register unchanged; no `done`. Repeating the test with reset in WH leaves the new value written.
- Back-to-back:
  - Stimulus: req0 issues a read in the same cycle as `done` of the prior write.
  - Required: grant at the next edge with no idle bubble.
